// File: rtl/dbg_cmd_sequencer.sv
// Debug command sequencer: decodes host UART commands, loads instruction memory,
// controls pipeline run/step and streams latch snapshots back byte-serially.
module dbg_cmd_sequencer #(
  parameter int MAX_INSTRUCTION = 64,
  parameter int ADDR_WIDTH      = 32,
  parameter int IF_ID_SIZE      = 32,
  parameter int ID_EX_SIZE      = 129,
  parameter int EX_MEM_SIZE     = 77,
  parameter int MEM_WB_SIZE     = 71
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_valid,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_start,
  input  logic                   i_tx_done,
  output logic                   o_imem_we,
  output logic [ADDR_WIDTH-1:0]  o_imem_addr,
  output logic [31:0]            o_imem_data,
  output logic                   o_stall,
  output logic                   o_pipe_rst,
  input  logic                   i_halt,
  input  logic [IF_ID_SIZE-1:0]  i_if_id,
  input  logic [ID_EX_SIZE-1:0]  i_id_ex,
  input  logic [EX_MEM_SIZE-1:0] i_ex_mem,
  input  logic [MEM_WB_SIZE-1:0] i_mem_wb,
  output logic                   o_step_mode,
  output logic                   o_busy
);

  localparam int SHW = 136;
  localparam logic [7:0] CHR_R = 8'h52;
  localparam logic [7:0] CHR_E = 8'h45;
  localparam logic [4:0] NB_IF_ID  = 5'((IF_ID_SIZE + 7) / 8);
  localparam logic [4:0] NB_ID_EX  = 5'((ID_EX_SIZE + 7) / 8);
  localparam logic [4:0] NB_EX_MEM = 5'((EX_MEM_SIZE + 7) / 8);
  localparam logic [4:0] NB_MEM_WB = 5'((MEM_WB_SIZE + 7) / 8);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_CNT, S_LOAD_DATA, S_RUN, S_DUMP, S_SEND, S_WAIT_TX
  } state_e;

  state_e                  state_q, state_d;
  logic                    step_mode_q, step_mode_d;
  logic                    loaded_q, loaded_d;
  logic                    stall_q, stall_d;
  logic                    pipe_rst_q, pipe_rst_d;
  logic                    imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]             imem_data_q, imem_data_d;
  logic [23:0]             asm_q, asm_d;
  logic [1:0]              byte_idx_q, byte_idx_d;
  logic [6:0]              word_cnt_q, word_cnt_d;
  logic [6:0]              n_words_q, n_words_d;
  logic [SHW-1:0]          shreg_q, shreg_d;
  logic [4:0]              bytes_left_q, bytes_left_d;
  logic [7:0]              term_q, term_d;
  logic                    last_q, last_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    tx_start_q, tx_start_d;

  always_comb begin
    state_d      = state_q;
    step_mode_d  = step_mode_q;
    loaded_d     = loaded_q;
    stall_d      = stall_q;
    pipe_rst_d   = 1'b0;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_data_d  = imem_data_q;
    asm_d        = asm_q;
    byte_idx_d   = byte_idx_q;
    word_cnt_d   = word_cnt_q;
    n_words_d    = n_words_q;
    shreg_d      = shreg_q;
    bytes_left_d = bytes_left_q;
    term_d       = term_q;
    last_d       = last_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;

    // A plain reply is a dump with no payload bytes, only the terminator.
    unique case (state_q)
      S_IDLE: begin
        if (i_rx_valid) begin
          bytes_left_d = '0;
          term_d       = CHR_E;
          state_d      = S_SEND;
          unique case (i_rx_data)
            8'h07: state_d = S_LOAD_CNT;
            8'h08: begin step_mode_d = 1'b0; state_d = S_IDLE; end
            8'h11: begin step_mode_d = 1'b1; state_d = S_IDLE; end
            8'h0D: begin
              if (loaded_q) begin
                pipe_rst_d = 1'b1;
                term_d     = CHR_R;
                if (!step_mode_q) state_d = S_RUN;
              end
            end
            8'h0A: begin
              if (loaded_q && step_mode_q && !i_halt) begin
                stall_d = 1'b0;
                term_d  = CHR_R;
              end
            end
            8'h02: begin shreg_d = SHW'(i_if_id);  bytes_left_d = NB_IF_ID;  term_d = CHR_R; state_d = S_DUMP; end
            8'h03: begin shreg_d = SHW'(i_id_ex);  bytes_left_d = NB_ID_EX;  term_d = CHR_R; state_d = S_DUMP; end
            8'h04: begin shreg_d = SHW'(i_ex_mem); bytes_left_d = NB_EX_MEM; term_d = CHR_R; state_d = S_DUMP; end
            8'h05: begin shreg_d = SHW'(i_mem_wb); bytes_left_d = NB_MEM_WB; term_d = CHR_R; state_d = S_DUMP; end
            default: ;
          endcase
        end
      end
      S_LOAD_CNT: begin
        if (i_rx_valid) begin
          loaded_d     = 1'b0;
          bytes_left_d = '0;
          if (i_rx_data == 8'd0 || 32'(i_rx_data) > 32'(MAX_INSTRUCTION)) begin
            term_d  = CHR_E;
            state_d = S_SEND;
          end else begin
            n_words_d  = i_rx_data[6:0];
            word_cnt_d = '0;
            byte_idx_d = '0;
            state_d    = S_LOAD_DATA;
          end
        end
      end
      S_LOAD_DATA: begin
        if (i_rx_valid) begin
          byte_idx_d = byte_idx_q + 2'd1;
          unique case (byte_idx_q)
            2'd0: asm_d[7:0]   = i_rx_data;
            2'd1: asm_d[15:8]  = i_rx_data;
            2'd2: asm_d[23:16] = i_rx_data;
            default: begin
              imem_we_d   = 1'b1;
              imem_data_d = {i_rx_data, asm_q};
              imem_addr_d = ADDR_WIDTH'({word_cnt_q, 2'b00});
              word_cnt_d  = word_cnt_q + 7'd1;
              if (word_cnt_q == n_words_q - 7'd1) begin
                loaded_d     = 1'b1;
                bytes_left_d = '0;
                term_d       = CHR_R;
                state_d      = S_SEND;
              end
            end
          endcase
        end
      end
      S_RUN: begin
        // Halt has priority; bytes arriving while running are ignored.
        if (i_halt) begin
          stall_d      = 1'b1;
          bytes_left_d = '0;
          term_d       = CHR_R;
          state_d      = S_SEND;
        end else begin
          stall_d = 1'b0;
        end
      end
      S_DUMP: state_d = S_SEND;
      S_SEND: begin
        stall_d    = 1'b1;
        tx_start_d = 1'b1;
        state_d    = S_WAIT_TX;
        if (bytes_left_q != 5'd0) begin
          tx_data_d    = shreg_q[7:0];
          shreg_d      = shreg_q >> 8;
          bytes_left_d = bytes_left_q - 5'd1;
          last_d       = 1'b0;
        end else begin
          tx_data_d = term_q;
          last_d    = 1'b1;
        end
      end
      S_WAIT_TX: begin
        if (i_tx_done) state_d = last_q ? S_IDLE : S_SEND;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      step_mode_q  <= 1'b0;
      loaded_q     <= 1'b0;
      stall_q      <= 1'b1;
      pipe_rst_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_data_q  <= '0;
      byte_idx_q   <= '0;
      word_cnt_q   <= '0;
      n_words_q    <= '0;
      bytes_left_q <= '0;
      term_q       <= '0;
      last_q       <= 1'b0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_mode_q  <= step_mode_d;
      loaded_q     <= loaded_d;
      stall_q      <= stall_d;
      pipe_rst_q   <= pipe_rst_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_data_q  <= imem_data_d;
      byte_idx_q   <= byte_idx_d;
      word_cnt_q   <= word_cnt_d;
      n_words_q    <= n_words_d;
      bytes_left_q <= bytes_left_d;
      term_q       <= term_d;
      last_q       <= last_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
    end
  end

  always_ff @(posedge i_clk) begin
    asm_q   <= asm_d;
    shreg_q <= shreg_d;
  end

  assign o_tx_data   = tx_data_q;
  assign o_tx_start  = tx_start_q;
  assign o_imem_we   = imem_we_q;
  assign o_imem_addr = imem_addr_q;
  assign o_imem_data = imem_data_q;
  assign o_stall     = stall_q;
  assign o_pipe_rst  = pipe_rst_q;
  assign o_step_mode = step_mode_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule
